// File: rtl/sine_phase_tracker_if.sv
// ---------------------------------------------------------------------------
// sine_phase_tracker_if
//   Sample-stream and result bundle of the sine phase tracker.
//   master : sample source / result consumer (drives i_valid, i_sample)
//   slave  : the tracker (drives the o_* results)
//   Signals:
//     i_valid        sample strobe, one sample per asserted cycle
//     i_sample       signed sine sample, WIDTH bits
//     o_period       last measured period in samples, CNT_W bits
//     o_period_valid one-cycle pulse when o_period updates
//     o_locked       phase output trustworthy
//     o_phase_count  recovered phase, $clog2(DEPTH) bits
//     o_step         current phase step, $clog2(DEPTH)+FRAC bits
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface sine_phase_tracker_if #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 1024,
  parameter int FRAC  = 16,
  parameter int CNT_W = 20
);
  localparam int PH_W = $clog2(DEPTH);

  logic                     i_valid;
  logic signed [WIDTH-1:0]  i_sample;
  logic [CNT_W-1:0]         o_period;
  logic                     o_period_valid;
  logic                     o_locked;
  logic [PH_W-1:0]          o_phase_count;
  logic [PH_W+FRAC-1:0]     o_step;

  modport master (
    output i_valid, i_sample,
    input  o_period, o_period_valid, o_locked, o_phase_count, o_step
  );

  modport slave (
    input  i_valid, i_sample,
    output o_period, o_period_valid, o_locked, o_phase_count, o_step
  );
endinterface

// File: rtl/sine_phase_tracker.sv
// ---------------------------------------------------------------------------
// sine_phase_tracker
//   Recovers period and instantaneous phase from a stream of signed sine
//   samples. Rising zero crossings delimit periods; an iterative restoring
//   divider turns the period into a phase step, and a phase accumulator
//   realigned at every crossing produces o_phase_count in the generator's
//   phase convention (0 = rising zero crossing, DEPTH/4 = positive peak).
//
//   Ports:
//     i_clk    clock
//     i_rst_n  asynchronous active-low reset
//     bus      sine_phase_tracker_if.slave (i_valid, i_sample in;
//              o_period, o_period_valid, o_locked, o_phase_count, o_step out)
//
//   Optional build macro SINE_PHASE_TRACKER_HYST_EN:
//     defined   -> arming needs sample <= -HYST (rejects chatter near zero)
//     undefined -> arming on any negative sample; HYST unused
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module sine_phase_tracker #(
  parameter int               WIDTH      = 24,
  parameter int               DEPTH      = 1024,
  parameter int               FRAC       = 16,
  parameter int               CNT_W      = 20,
  parameter int               MIN_PERIOD = 32,
  parameter int               TOL        = 2,
  parameter logic [WIDTH-1:0] HYST       = 24'h000400
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  sine_phase_tracker_if.slave bus
);

  localparam int PH_W      = $clog2(DEPTH);
  localparam int ACC_W     = PH_W + FRAC;
  // Dividend DEPTH<<FRAC needs one bit more than the step itself.
  localparam int DIV_W     = ACC_W + 1;
  localparam int DIV_CNT_W = $clog2(DIV_W + 1);

  localparam logic [DIV_W-1:0]     DIVIDEND  = DIV_W'(DEPTH) << FRAC;
  localparam logic [CNT_W-1:0]     MIN_C     = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0]     TOL_C     = CNT_W'(TOL);
  localparam logic signed [WIDTH-1:0] ZERO   = '0;

  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;

  // Saturating period counter increment.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  state_t               r_state, w_state_nxt;
  logic                 r_armed;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     r_period;
  logic                 r_pvld;
  logic [ACC_W-1:0]     r_acc;
  logic [ACC_W-1:0]     r_step;
  logic                 r_step_vld;

  logic                 r_div_busy;
  logic [DIV_CNT_W-1:0] r_div_cnt;
  logic [CNT_W-1:0]     r_div_rem;
  logic [DIV_W-1:0]     r_div_q;
  logic [CNT_W-1:0]     r_div_den;

  logic                 w_arm;
  logic                 w_cross;
  logic                 w_long;
  logic                 w_in_tol;
  logic                 w_cnt_max;
  logic                 w_accept;
  logic [CNT_W:0]       w_shift;
  logic                 w_ge;
  logic [CNT_W-1:0]     w_rem_sub;

`ifdef SINE_PHASE_TRACKER_HYST_EN
  localparam logic signed [WIDTH-1:0] NEG_HYST = -$signed(HYST);
  assign w_arm = (bus.i_sample <= NEG_HYST);
`else
  // HYST has no role without the hysteresis option; sink keeps it referenced.
  logic w_unused_hyst;
  assign w_unused_hyst = ^HYST;
  assign w_arm = (bus.i_sample < ZERO);
`endif

  assign w_cross   = bus.i_valid && r_armed && (bus.i_sample >= ZERO);
  assign w_long    = (r_cnt >= MIN_C);
  assign w_in_tol  = (abs_diff(r_cnt, r_period) <= TOL_C);
  assign w_cnt_max = &r_cnt;

  // Next state and period acceptance.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    if (bus.i_valid) begin
      if (w_cross) begin
        case (r_state)
          IDLE:    w_state_nxt = MEASURE;
          MEASURE: begin
            w_accept = w_long;
            if (w_long && w_in_tol) w_state_nxt = LOCKED;
          end
          LOCKED: begin
            w_accept = w_long;
            if (!(w_long && w_in_tol)) w_state_nxt = MEASURE;
          end
          default: w_state_nxt = IDLE;
        endcase
      end else if (w_cnt_max) begin
        // No crossing within the counter range: the signal is gone.
        w_state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Sample stage: arming, period counter, period capture, accumulator.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_armed  <= 1'b0;
      r_cnt    <= '0;
      r_period <= '0;
      r_pvld   <= 1'b0;
      r_acc    <= '0;
    end else begin
      r_pvld <= w_accept;
      if (w_accept) r_period <= r_cnt;
      if (bus.i_valid) begin
        if (w_cross) begin
          r_armed <= 1'b0;
          r_cnt   <= CNT_W'(1);
          r_acc   <= '0;
        end else begin
          if (w_arm) r_armed <= 1'b1;
          r_cnt <= sat_inc(r_cnt);
          r_acc <= r_acc + r_step;
        end
      end
    end
  end

  // Restoring divider: one quotient bit per clock, dividend bits shift in
  // from the top of r_div_q while quotient bits enter at the bottom.
  assign w_shift   = {r_div_rem, r_div_q[DIV_W-1]};
  assign w_ge      = (w_shift >= {1'b0, r_div_den});
  assign w_rem_sub = w_shift[CNT_W-1:0] - r_div_den;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div_busy <= 1'b0;
      r_div_cnt  <= '0;
      r_div_rem  <= '0;
      r_div_q    <= '0;
      r_div_den  <= '0;
      r_step     <= '0;
      r_step_vld <= 1'b0;
    end else if (w_accept) begin
      // A new period restarts the division; r_step holds until it finishes.
      r_div_busy <= 1'b1;
      r_div_cnt  <= DIV_CNT_W'(DIV_W);
      r_div_rem  <= '0;
      r_div_q    <= DIVIDEND;
      r_div_den  <= r_cnt;
    end else if (r_div_busy) begin
      r_div_rem <= w_ge ? w_rem_sub : w_shift[CNT_W-1:0];
      r_div_q   <= {r_div_q[DIV_W-2:0], w_ge};
      r_div_cnt <= r_div_cnt - DIV_CNT_W'(1);
      if (r_div_cnt == DIV_CNT_W'(1)) begin
        // Quotient fits ACC_W bits because the period is at least MIN_PERIOD.
        r_div_busy <= 1'b0;
        r_step     <= {r_div_q[ACC_W-2:0], w_ge};
        r_step_vld <= 1'b1;
      end
    end
  end

  assign bus.o_period       = r_period;
  assign bus.o_period_valid = r_pvld;
  assign bus.o_locked       = (r_state == LOCKED) && r_step_vld;
  assign bus.o_phase_count  = r_acc[ACC_W-1 -: PH_W];
  assign bus.o_step         = r_step;

endmodule

// File: tb/tb_sine_phase_tracker.sv
`timescale 1ns/1ps
module tb_sine_phase_tracker;

  localparam int WIDTH = 24;
  localparam int DEPTH = 1024;
  localparam int FRAC  = 16;
  localparam int CNT_W = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sine_phase_tracker_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FRAC(FRAC), .CNT_W(CNT_W)) bus ();

  sine_phase_tracker #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .FRAC(FRAC), .CNT_W(CNT_W),
    .MIN_PERIOD(32), .TOL(2), .HYST(24'h000400)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  typedef enum int {K_PERIOD, K_PVLD, K_LOCKED, K_PHASE, K_STEP} kind_t;
  typedef struct {
    string       tag;
    kind_t       kind;
    logic [63:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic sb_push(input string tag, input kind_t k, input longint v);
    exp_t e;
    e.tag  = tag;
    e.kind = k;
    e.exp  = v;
    sb.push_back(e);
  endtask

  function automatic logic [63:0] observe(input kind_t k);
    case (k)
      K_PERIOD: return 64'(bus.o_period);
      K_PVLD:   return 64'(bus.o_period_valid);
      K_LOCKED: return 64'(bus.o_locked);
      K_PHASE:  return 64'(bus.o_phase_count);
      default:  return 64'(bus.o_step);
    endcase
  endfunction

  // Triangle-shaped test wave: ph=0 is the rising zero crossing,
  // first half non-negative, second half negative.
  function automatic logic signed [WIDTH-1:0] wav(input int ph, input int p);
    if (ph < p / 2) return WIDTH'(ph * 1000);
    else            return WIDTH'(-(ph - p / 2 + 1) * 1000);
  endfunction

  function automatic longint phase_of(input longint k, input longint step);
    return ((k * step) >> FRAC) % DEPTH;
  endfunction

  // Drive one valid sample, then compare every expectation queued for it.
  task automatic send(input logic signed [WIDTH-1:0] s);
    exp_t e;
    bus.i_valid  = 1'b1;
    bus.i_sample = s;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq(e.tag, observe(e.kind), e.exp);
    end
  endtask

  task automatic check_zero(input string pfx);
    check_eq({pfx, "_period"}, 64'(bus.o_period), 0);
    check_eq({pfx, "_pvld"},   64'(bus.o_period_valid), 0);
    check_eq({pfx, "_locked"}, 64'(bus.o_locked), 0);
    check_eq({pfx, "_phase"},  64'(bus.o_phase_count), 0);
    check_eq({pfx, "_step"},   64'(bus.o_step), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ph;
    int len;
    int prev;
    logic signed [WIDTH-1:0] s;

    bus.i_valid  = 1'b0;
    bus.i_sample = '0;
    rst_n        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("rst_init");
    @(negedge clk);
    rst_n = 1'b1;

    // Clean period 100, entering mid-period so the first crossing is armed.
    for (int n = 50; n < 440; n++) begin
      ph = n % 100;
      if (n == 200) begin
        sb_push("p100_period", K_PERIOD, 100);
        sb_push("p100_pvld", K_PVLD, 1);
        sb_push("p100_nolock_c2", K_LOCKED, 0);
      end
      if (n == 201) sb_push("p100_pvld_end", K_PVLD, 0);
      if (n == 299) sb_push("p100_nolock_pre", K_LOCKED, 0);
      if (n == 300) begin
        sb_push("p100_locked", K_LOCKED, 1);
        sb_push("p100_step", K_STEP, 671088);
      end
      if (n == 325) sb_push("p100_phase25", K_PHASE, 255);
      if (n == 350) sb_push("p100_phase50", K_PHASE, 511);
      if (n == 400) sb_push("p100_phase0", K_PHASE, 0);
      if (n == 437) sb_push("p100_phase37", K_PHASE, phase_of(37, 671088));
      send(wav(ph, 100));
    end
    for (int n = 440; n < 500; n++) send(wav(n % 100, 100));

    // Period jump to 110, relock, then a glitch crossing 10 samples in.
    for (int m = 0; m < 445; m++) begin
      ph = m % 110;
      s  = wav(ph, 110);
      if (m == 339) s = -24'sd5;
      if (m == 340) s = 24'sd5;
      if (m == 0) begin
        sb_push("j_keep_locked", K_LOCKED, 1);
        sb_push("j_keep_period", K_PERIOD, 100);
      end
      if (m == 110) begin
        sb_push("j_period110", K_PERIOD, 110);
        sb_push("j_pvld110", K_PVLD, 1);
        sb_push("j_unlock", K_LOCKED, 0);
      end
      if (m == 115) sb_push("j_step_held", K_STEP, 671088);
      if (m == 136) sb_push("j_step_lat26", K_STEP, 671088);
      if (m == 137) sb_push("j_step_lat27", K_STEP, 610080);
      if (m == 220) begin
        sb_push("j_relock", K_LOCKED, 1);
        sb_push("j_relock_pvld", K_PVLD, 1);
        sb_push("j_relock_step", K_STEP, 610080);
      end
      if (m == 275) sb_push("j_phase55", K_PHASE, 511);
      if (m == 330) sb_push("g_locked_pre", K_LOCKED, 1);
      if (m == 340) begin
        sb_push("g_no_pvld", K_PVLD, 0);
        sb_push("g_period_kept", K_PERIOD, 110);
        sb_push("g_unlock", K_LOCKED, 0);
        sb_push("g_phase_realign", K_PHASE, 0);
      end
      if (m == 341) sb_push("g_phase1", K_PHASE, phase_of(1, 610080));
      if (m == 440) begin
        sb_push("g_cnt_restart", K_PERIOD, 100);
        sb_push("g_cnt_pvld", K_PVLD, 1);
        sb_push("g_still_unlocked", K_LOCKED, 0);
      end
      send(s);
    end

    // Asynchronous reset mid-stream with valid samples still flowing.
    rst_n = 1'b0;
    #1;
    check_zero("rst_async");
    repeat (3) @(posedge clk);
    #1;
    check_zero("rst_held");
    @(negedge clk);
    rst_n = 1'b1;

    // First period after reset must not lock; the second consistent one does.
    for (int n = 50; n < 301; n++) begin
      ph = n % 100;
      if (n == 200) begin
        sb_push("r_period", K_PERIOD, 100);
        sb_push("r_first_nolock", K_LOCKED, 0);
      end
      if (n == 300) sb_push("r_relock", K_LOCKED, 1);
      send(wav(ph, 100));
    end

    // Noise near zero: a lone -0x100 sample every 40/50 samples.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      len  = (k % 2 == 1) ? 50 : 40;
      prev = (k % 2 == 1) ? 40 : 50;
      for (int j = 0; j < len; j++) begin
        if (j == 1) begin
          sb_push($sformatf("noise_nolock_%0d", k), K_LOCKED, 0);
          if (k > 0) begin
`ifdef SINE_PHASE_TRACKER_HYST_EN
            sb_push($sformatf("noise_pvld_%0d", k), K_PVLD, 0);
            sb_push($sformatf("noise_period_%0d", k), K_PERIOD, 0);
`else
            sb_push($sformatf("noise_pvld_%0d", k), K_PVLD, 1);
            sb_push($sformatf("noise_period_%0d", k), K_PERIOD, prev);
`endif
          end
        end
        send((j == 0) ? -24'sh000100 : 24'sh000100);
      end
    end

    bus.i_valid = 1'b0;
    check_eq("sb_drained", 64'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
